// File: rtl/cpu_0_jtag_ocimem_responder.sv
// JTAG/CPU shared on-chip memory responder: one 256x32 synchronous RAM, JTAG
// debug FSM with strict priority over a CPU slave port.

module cpu_0_jtag_ocimem_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] q
);
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // No reset: contents survive reset; q is read-before-write.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         q <= mem[addr];
      end
   end
endmodule

module cpu_0_jtag_ocimem_responder #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] cpu_address,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [DATA_W-1:0] cpu_writedata,
   output logic [DATA_W-1:0] cpu_readdata,
   output logic              cpu_readdatavalid,
   output logic              cpu_waitrequest,
   output logic [DATA_W-1:0] MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error
);
   localparam int STAGES = 1;

   typedef enum logic [1:0] {IDLE, JRD, JWR, DONE} state_t;

   typedef struct packed {
      logic              en;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } ram_req_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] jaddr;
   logic [DATA_W-1:0] wdata_q;
   logic              op_rd;
   logic [STAGES:0]   vld_pipe;
   ram_req_t          ram_req;
   logic [DATA_W-1:0] ram_q;

   logic sa, sb, sn, any_strobe, multi_strobe, idle;
   logic acc_a, acc_b, acc_n, err_set, err_clr;
   logic cpu_req, cpu_grant, cpu_rd_grant;

   assign sa           = take_action_ocimem_a;
   assign sb           = take_action_ocimem_b;
   assign sn           = take_no_action_ocimem_a;
   assign any_strobe   = sa | sb | sn;
   assign multi_strobe = (sa & sb) | (sa & sn) | (sb & sn);
   assign idle         = (state == IDLE);

   // JTAG owns the RAM whenever it is busy or a strobe is pending.
   assign cpu_req         = cpu_read | cpu_write;
   assign cpu_grant       = cpu_req & idle & ~any_strobe;
   assign cpu_rd_grant    = cpu_grant & ~cpu_write;
   assign cpu_waitrequest = cpu_req & ~(idle & ~any_strobe);

   assign err_set = any_strobe & (~idle | multi_strobe);
   assign err_clr = acc_a & jdo[35];

   always_comb begin
      state_nxt = state;
      acc_a     = 1'b0;
      acc_b     = 1'b0;
      acc_n     = 1'b0;
      case (state)
         IDLE: begin
            if (sa) begin
               acc_a = 1'b1;
               if (jdo[17]) state_nxt = JRD;
            end else if (sb) begin
               acc_b     = 1'b1;
               state_nxt = JWR;
            end else if (sn) begin
               acc_n     = 1'b1;
               state_nxt = JRD;
            end
         end
         JRD:     state_nxt = DONE;
         JWR:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ram_req = '0;
      if (state == JWR) begin
         ram_req.en    = 1'b1;
         ram_req.we    = 1'b1;
         ram_req.addr  = jaddr;
         ram_req.wdata = wdata_q;
      end else if (state == JRD) begin
         ram_req.en   = 1'b1;
         ram_req.addr = jaddr;
      end else if (cpu_grant) begin
         ram_req.en    = 1'b1;
         ram_req.we    = cpu_write;
         ram_req.addr  = cpu_address;
         ram_req.wdata = cpu_writedata;
      end
   end

   cpu_0_jtag_ocimem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk   (clk),
      .en    (ram_req.en),
      .we    (ram_req.we),
      .addr  (ram_req.addr),
      .wdata (ram_req.wdata),
      .q     (ram_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         jaddr         <= '0;
         wdata_q       <= '0;
         op_rd         <= 1'b0;
         MonDReg       <= '0;
         monitor_ready <= 1'b1;
         monitor_error <= 1'b0;
      end else begin
         if (acc_a)              jaddr <= jdo[33:26];
         else if (state == DONE) jaddr <= jaddr + 1'b1;
         if (acc_b) wdata_q <= jdo[34:3];
         if (idle)  op_rd   <= (state_nxt == JRD);
         if (state == DONE && op_rd) MonDReg <= ram_q;
         // A load-address without read leaves the FSM idle, so ready stays high.
         if (idle && state_nxt != IDLE) monitor_ready <= 1'b0;
         else if (state == DONE)        monitor_ready <= 1'b1;
         if (err_set)      monitor_error <= 1'b1;
         else if (err_clr) monitor_error <= 1'b0;
      end
   end

   // CPU read return: grant edge -> RAM q -> registered readdata.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe     <= '0;
         cpu_readdata <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], cpu_rd_grant};
         if (vld_pipe[STAGES-1]) cpu_readdata <= ram_q;
      end
   end

   assign cpu_readdatavalid = vld_pipe[STAGES];

   logic unused_jdo;
   assign unused_jdo = ^{jdo[37:36], jdo[2:0], acc_n};
endmodule

// File: tb/tb_cpu_0_jtag_ocimem_responder.sv
// Scoreboard bench: stimulus pushes expected JTAG/CPU results, a negedge
// monitor pops and compares data and arrival cycle.

module tb_cpu_0_jtag_ocimem_responder;
   logic        clk = 1'b0;
   logic        reset;
   logic [37:0] jdo;
   logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [7:0]  cpu_address;
   logic        cpu_read, cpu_write;
   logic [31:0] cpu_writedata, cpu_readdata, MonDReg;
   logic        cpu_readdatavalid, cpu_waitrequest, monitor_ready, monitor_error;

   cpu_0_jtag_ocimem_responder dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .cpu_address             (cpu_address),
      .cpu_read                (cpu_read),
      .cpu_write               (cpu_write),
      .cpu_writedata           (cpu_writedata),
      .cpu_readdata            (cpu_readdata),
      .cpu_readdatavalid       (cpu_readdatavalid),
      .cpu_waitrequest         (cpu_waitrequest),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] data; int cyc; } exp_t;
   exp_t jq[$];
   exp_t cq[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic prev_rdy = 1'b1;
   logic [31:0] last_mon = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: CPU read returns and JTAG completions (rising monitor_ready).
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (cpu_readdatavalid) begin
            if (cq.size() == 0) chk("cpu_unexpected_valid", 32'd1, 32'd0);
            else begin
               e = cq.pop_front();
               chk("cpu_readdata", cpu_readdata, e.data);
               chk("cpu_valid_cycle", cyc, e.cyc);
            end
         end
         if (monitor_ready && !prev_rdy) begin
            if (jq.size() == 0) chk("jtag_unexpected_ready", 32'd1, 32'd0);
            else begin
               e = jq.pop_front();
               chk("jtag_mondreg", MonDReg, e.data);
               chk("jtag_ready_cycle", cyc, e.cyc);
            end
         end
      end
      prev_rdy = monitor_ready;
   end

   function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd, input logic clr);
      logic [37:0] d;
      d = '0;
      d[33:26] = a;
      d[17] = rd;
      d[35] = clr;
      return d;
   endfunction

   function automatic logic [37:0] mk_b(input logic [31:0] data);
      logic [37:0] d;
      d = '0;
      d[34:3] = data;
      return d;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic jstrobe(input logic a, input logic b, input logic n, input logic [37:0] d,
                          input logic push, input logic [31:0] exp);
      exp_t e;
      take_action_ocimem_a = a;
      take_action_ocimem_b = b;
      take_no_action_ocimem_a = n;
      jdo = d;
      if (push) begin
         e.data = exp;
         e.cyc = cyc + 3;
         jq.push_back(e);
      end
      tick();
      take_action_ocimem_a = 0;
      take_action_ocimem_b = 0;
      take_no_action_ocimem_a = 0;
      jdo = '0;
   endtask

   task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
      int k;
      cpu_write = 1; cpu_address = a; cpu_writedata = d;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!cpu_waitrequest) break;
      end
      if (k == 20) chk("cpu_wr_timeout", 32'd1, 32'd0);
      tick();
      cpu_write = 0;
   endtask

   task automatic cpu_rd(input logic [7:0] a, input logic [31:0] exp, output int waits);
      exp_t e;
      int k;
      waits = 0;
      cpu_read = 1; cpu_address = a;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!cpu_waitrequest) begin
            e.data = exp;
            e.cyc = cyc + 2;
            cq.push_back(e);
            break;
         end
         waits++;
      end
      if (k == 20) chk("cpu_rd_timeout", 32'd1, 32'd0);
      tick();
      cpu_read = 0;
   endtask

   initial begin
      int w, w2;
      reset = 1; jdo = '0;
      take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
      cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", monitor_ready, 1);
      chk("rst_error", monitor_error, 0);
      chk("rst_mondreg", MonDReg, 0);
      chk("rst_rdvalid", cpu_readdatavalid, 0);
      chk("rst_rddata", cpu_readdata, 0);
      cpu_read = 1; #1;
      chk("rst_waitreq_free", cpu_waitrequest, 0);
      take_no_action_ocimem_a = 1; #1;
      chk("rst_waitreq_strobe", cpu_waitrequest, 1);
      take_no_action_ocimem_a = 0; cpu_read = 0;
      tick();
      reset = 0;
      tick();

      cpu_wr(8'h11, 32'h1111_1111);
      cpu_wr(8'hFF, 32'h1234_5678);
      cpu_wr(8'h00, 32'hCAFE_F00D);
      cpu_wr(8'h01, 32'h0000_0101);
      cpu_wr(8'h02, 32'h0000_0202);
      cpu_wr(8'h30, 32'h0000_3030);
      cpu_wr(8'h21, 32'h0000_2121);
      cpu_wr(8'h40, 32'h0000_4040);

      // Load address 0x10 without read, then JTAG write.
      jstrobe(1, 0, 0, mk_a(8'h10, 0, 0), 0, 0);
      @(negedge clk);
      chk("load_only_ready", monitor_ready, 1);
      tick();
      jstrobe(0, 1, 0, mk_b(32'hDEAD_BEEF), 1, last_mon);
      repeat (3) tick();
      cpu_rd(8'h10, 32'hDEAD_BEEF, w);
      repeat (2) tick();
      jstrobe(0, 0, 1, '0, 1, 32'h1111_1111);
      last_mon = 32'h1111_1111;
      repeat (3) tick();

      // Read at 0xFF, then wrap to 0x00.
      jstrobe(1, 0, 0, mk_a(8'hFF, 1, 0), 1, 32'h1234_5678);
      repeat (3) tick();
      jstrobe(0, 0, 1, '0, 1, 32'hCAFE_F00D);
      repeat (3) tick();

      // Back-to-back read-next: second is an error, one increment only.
      take_no_action_ocimem_a = 1;
      jq.push_back('{32'h0000_0101, cyc + 3});
      tick();
      tick();
      take_no_action_ocimem_a = 0;
      repeat (3) tick();
      chk("err_sticky", monitor_error, 1);
      jstrobe(0, 0, 1, '0, 1, 32'h0000_0202);
      repeat (3) tick();
      chk("err_still_set", monitor_error, 1);
      jstrobe(1, 0, 0, mk_a(8'h00, 0, 1), 0, 0);
      @(negedge clk);
      chk("err_cleared", monitor_error, 0);
      tick();

      // Simultaneous a+b: a wins (read 0x30), error flagged.
      jstrobe(1, 1, 0, mk_a(8'h30, 1, 0), 1, 32'h0000_3030);
      @(negedge clk);
      chk("err_multi", monitor_error, 1);
      repeat (3) tick();
      cpu_rd(8'h30, 32'h0000_3030, w);
      last_mon = 32'h0000_3030;
      jstrobe(1, 0, 0, mk_a(8'h20, 0, 1), 0, 0);
      @(negedge clk);
      chk("err_cleared2", monitor_error, 0);
      tick();

      // CPU read held across JTAG write to the same address.
      fork
         jstrobe(0, 1, 0, mk_b(32'hA5A5_A5A5), 1, last_mon);
         cpu_rd(8'h20, 32'hA5A5_A5A5, w);
      join
      chk("cpu_wait_cycles", w, 3);
      repeat (4) tick();

      // JTAG strobe in the cycle after a CPU grant.
      fork
         cpu_rd(8'h10, 32'hDEAD_BEEF, w2);
         begin tick(); jstrobe(0, 0, 1, '0, 1, 32'h0000_2121); end
      join
      chk("cpu_nowait", w2, 0);
      repeat (4) tick();

      // Reset while in JWR, before the write edge.
      jstrobe(1, 0, 0, mk_a(8'h40, 0, 0), 0, 0);
      jstrobe(0, 1, 0, mk_b(32'hBAD0_BAD0), 0, 0);
      reset = 1; #1;
      chk("midrst_ready", monitor_ready, 1);
      chk("midrst_mondreg", MonDReg, 0);
      tick();
      reset = 0;
      tick();
      cpu_rd(8'h40, 32'h0000_4040, w);
      repeat (2) tick();
      jstrobe(0, 0, 1, '0, 1, 32'hCAFE_F00D);

      for (int i = 0; i < 60 && (jq.size() != 0 || cq.size() != 0); i++) tick();
      chk("queues_drained", jq.size() + cq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cpu_0_jtag_ocimem_responder.md
CPU_0_JTAG_OCIMEM_RESPONDER -- requirements
Module: cpu_0_jtag_ocimem_responder

Interface
REQ-001 The module SHALL have the port `clk`, input, 1 bit: the single clock; all logic is rising-edge.
REQ-002 The module SHALL have the port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have the port `jdo`, input, 38 bits: JTAG command payload, valid only in a strobe cycle.
REQ-004 The module SHALL have the port `take_action_ocimem_a`, input, 1 bit: load-address strobe.
REQ-005 The module SHALL have the port `take_action_ocimem_b`, input, 1 bit: write-data strobe.
REQ-006 The module SHALL have the port `take_no_action_ocimem_a`, input, 1 bit: read-next strobe.
REQ-007 The module SHALL have the port `cpu_address`, input, 8 bits: CPU word address.
REQ-008 The module SHALL have the port `cpu_read`, input, 1 bit, and the port `cpu_write`, input, 1 bit: CPU request qualifiers.
REQ-009 The module SHALL have the port `cpu_writedata`, input, 32 bits: CPU write data.
REQ-010 The module SHALL have the port `cpu_readdata`, output, 32 bits, and the port `cpu_readdatavalid`, output, 1 bit: CPU read return.
REQ-011 The module SHALL have the port `cpu_waitrequest`, output, 1 bit: CPU request stalled this cycle.
REQ-012 The module SHALL have the port `MonDReg`, output, 32 bits: data returned to the JTAG side.
REQ-013 The module SHALL have the port `monitor_ready`, output, 1 bit, and the port `monitor_error`, output, 1 bit: JTAG completion flag and sticky error flag.

Function
REQ-014 The module SHALL contain a 256 x 32 single-port synchronous RAM with read data registered one cycle after the address, shared by the JTAG and CPU sides.
REQ-015 The module SHALL keep an 8-bit JTAG address pointer `jaddr` that increments modulo 256 (255 -> 0) after every JTAG read or write.
REQ-016 The JTAG state machine SHALL have states IDLE, JRD (RAM read issued), JWR (RAM write issued) and DONE (result posted, one cycle), all returning to IDLE.
REQ-017 On `take_action_ocimem_a` in IDLE: `jaddr` SHALL load `jdo[33:26]`; if `jdo[35]`=1, `monitor_error` SHALL clear; if `jdo[17]`=1, the state SHALL go to JRD, otherwise it SHALL stay in IDLE with `monitor_ready` remaining 1.
REQ-018 On `take_no_action_ocimem_a` in IDLE, the state SHALL go to JRD.
REQ-019 On `take_action_ocimem_b` in IDLE, the state SHALL go to JWR with data `jdo[34:3]`.
REQ-020 In JRD the RAM SHALL be read at `jaddr`; in DONE, `MonDReg` SHALL take the RAM data and `jaddr` SHALL increment.
REQ-021 In JWR the RAM SHALL be written at `jaddr`; `jaddr` SHALL increment in DONE; `MonDReg` SHALL be unchanged by writes.
REQ-022 `monitor_ready` SHALL be 0 from the cycle after an accepted strobe until DONE, and 1 from the cycle after DONE: strobe in cycle N gives `monitor_ready`=1 at N+3 for both reads and writes.
REQ-023 Any JTAG strobe arriving while the state is not IDLE SHALL be ignored and SHALL set `monitor_error`, which is sticky until cleared per REQ-017 or by reset.
REQ-024 If more than one JTAG strobe is asserted in the same cycle, the priority SHALL be `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`, only the winner SHALL execute, and `monitor_error` SHALL be set.
REQ-025 CPU access SHALL be granted only when the JTAG state is IDLE and no JTAG strobe is asserted; otherwise `cpu_waitrequest` SHALL equal (`cpu_read` | `cpu_write`), giving JTAG strict priority.
REQ-026 A granted CPU write SHALL update the RAM at the next edge.
REQ-027 A granted CPU read SHALL drive `cpu_readdata` with `cpu_readdatavalid`=1 for exactly one cycle, two cycles after grant.
REQ-028 `cpu_read` and `cpu_write` asserted together SHALL be treated as a write.
REQ-029 A JTAG strobe arriving in the cycle after a CPU grant SHALL be accepted normally, and the in-flight CPU read SHALL still complete.

Reset
REQ-030 While `reset`=1, asynchronously: state SHALL be IDLE, `jaddr`=0, `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, `cpu_readdatavalid`=0, `cpu_readdata`=0; `cpu_waitrequest` SHALL follow REQ-025.
REQ-031 Reset mid-operation SHALL abort the operation with no write committed unless the RAM write edge has already occurred; RAM contents SHALL not be cleared.

Verification
REQ-032 Bench scenario: `take_action_ocimem_a`, `jdo[33:26]`=0x10, `jdo[17]`=0, then `take_action_ocimem_b` with data 0xDEADBEEF -> RAM[0x10]=0xDEADBEEF, `jaddr`=0x11, `monitor_ready` rises 3 cycles after `take_action_ocimem_b`.
REQ-033 Bench scenario: load address 0xFF with `jdo[17]`=1 after RAM[0xFF]=0x12345678 -> `MonDReg`=0x12345678, `jaddr` wraps to 0x00; a following `take_no_action_ocimem_a` returns RAM[0x00].
REQ-034 Bench scenario: `take_no_action_ocimem_a` asserted again one cycle after the first -> `monitor_error`=1, single increment; then load address with `jdo[35]`=1 -> `monitor_error`=0.
REQ-035 Bench scenario: `cpu_read` held at address 0x20 while a JTAG write to 0x20 of 0xA5A5A5A5 is in progress -> `cpu_waitrequest`=1 until IDLE, then `cpu_readdata`=0xA5A5A5A5 with `cpu_readdatavalid` pulsed once.
REQ-036 Bench scenario: `reset` asserted in JWR before the write edge -> RAM unchanged, `monitor_ready`=1 and `jaddr`=0 immediately.
